// File: rtl/mult_result_stage.sv
// rtl/mult_result_stage.sv - two-stage multiplier result select / FMULS normalize-round pipeline
module mult_result_stage #(
    parameter int ROUND_RNE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [65:0] mult_result,
    input  logic [4:0]  ID_EX_alu_func,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_FMULS  = 5'h14;

    // S1 capture registers
    logic        s1_valid_q;
    logic [4:0]  func_q;
    logic [47:0] p_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        sign_q;
    logic [9:0]  esum_q;
    logic        zero_q;
    logic        special_q;

    // S2 output registers
    logic        s2_valid_q;
    logic [31:0] result_q;
    logic [31:0] result_d;

    logic        advance;

    // Product sign-extension bits and FP mantissa fields of the operands are not needed here
    logic        unused_bits;
    assign unused_bits = ^{mult_result[65:64], opa[22:0], opb[22:0]};

    assign advance   = !s2_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = s2_valid_q;
    assign result    = result_q;

    // S1: capture the product and decode the FMULS operand exponents
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            func_q     <= '0;
            p_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sign_q     <= 1'b0;
            esum_q     <= '0;
            zero_q     <= 1'b0;
            special_q  <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                func_q    <= ID_EX_alu_func;
                p_q       <= mult_result[47:0];
                hi_q      <= mult_result[63:32];
                lo_q      <= mult_result[31:0];
                sign_q    <= opa[31] ^ opb[31];
                esum_q    <= {2'b00, opa[30:23]} + {2'b00, opb[30:23]};
                zero_q    <= (opa[30:23] == 8'h00) || (opb[30:23] == 8'h00);
                special_q <= (opa[30:23] == 8'hFF) || (opb[30:23] == 8'hFF);
            end
        end
    end

    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic signed [9:0] exp_n;
    logic              inc;
    logic [23:0]       mant_r;
    logic [22:0]       mant_f;
    logic signed [9:0] exp_f;
    logic [31:0]       fp_res;

    // S2 datapath: normalize the 48-bit mantissa product, round, then pick special-case encodings
    always_comb begin
        if (p_q[47]) begin
            mant   = p_q[46:24];
            guard  = p_q[23];
            sticky = |p_q[22:0];
            exp_n  = $signed(esum_q - 10'd126);
        end else begin
            mant   = p_q[45:23];
            guard  = p_q[22];
            sticky = |p_q[21:0];
            exp_n  = $signed(esum_q - 10'd127);
        end
        inc    = (ROUND_RNE != 0) && guard && (sticky || mant[0]);
        mant_r = {1'b0, mant} + {23'd0, inc};
        if (mant_r[23]) begin
            mant_f = '0;
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_r[22:0];
            exp_f  = exp_n;
        end
        if (special_q && zero_q) begin
            fp_res = 32'h7FC00000;
        end else if (special_q) begin
            fp_res = {sign_q, 8'hFF, 23'h0};
        end else if (zero_q) begin
            fp_res = {sign_q, 31'h0};
        end else if (exp_f >= 10'sd255) begin
            fp_res = {sign_q, 8'hFF, 23'h0};
        end else if (exp_f <= 10'sd0) begin
            fp_res = {sign_q, 31'h0};
        end else begin
            fp_res = {sign_q, exp_f[7:0], mant_f};
        end
    end

    // S2 result select by operation code
    always_comb begin
        case (func_q)
            ALU_MUL:                         result_d = lo_q;
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result_d = hi_q;
            ALU_FMULS:                       result_d = fp_res;
            default:                         result_d = lo_q;
        endcase
    end

    // S2: register the selected result; held while downstream stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_mult_result_stage.sv
// tb/tb_mult_result_stage.sv - scoreboard bench for mult_result_stage
module tb_mult_result_stage;

    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_FMULS  = 5'h14;
    localparam logic [4:0] ALU_OTHER  = 5'h03;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [65:0] mult_result;
    logic [4:0]  ID_EX_alu_func;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    mult_result_stage #(.ROUND_RNE(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mult_result    (mult_result),
        .ID_EX_alu_func (ID_EX_alu_func),
        .opa            (opa),
        .opb            (opb),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every transfer on the output is matched against the oldest expected result
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [65:0] mr);
        in_valid       = 1'b1;
        ID_EX_alu_func = f;
        opa            = a;
        opb            = b;
        mult_result    = mr;
    endtask

    task automatic send(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [65:0] mr, input logic [31:0] expv);
        bit done;
        done = 1'b0;
        drive(f, a, b, mr);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(expv);
                @(posedge clock);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        mult_result    = '0;
        ID_EX_alu_func = '0;
        opa            = '0;
        opb            = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // MUL 7 * -3 with latency check
        send(ALU_MUL, 32'd7, 32'hFFFFFFFD, 66'h3_FFFF_FFFF_FFFF_FFEB, 32'hFFFFFFEB);
        @(negedge clock);
        check("lat_edge_n", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        check("lat_edge_n1", {31'd0, out_valid}, 32'd1);
        @(posedge clock);
        #1;

        // Back-to-back directed vectors
        send(ALU_MULH,   32'd7, 32'hFFFFFFFD, 66'h3_FFFF_FFFF_FFFF_FFEB, 32'hFFFFFFFF);
        send(ALU_MULHU,  32'd0, 32'd0, 66'h0_FFFF_FFFE_0000_0001, 32'hFFFFFFFE);
        send(ALU_MULHSU, 32'd0, 32'd0, 66'h0_1234_5678_9ABC_DEF0, 32'h12345678);
        send(ALU_OTHER,  32'd0, 32'd0, 66'h0_1234_5678_9ABC_DEF0, 32'h9ABCDEF0);
        send(ALU_FMULS,  32'h40000000, 32'h40400000, {18'd0, 48'h6000_0000_0000}, 32'h40C00000);
        send(ALU_FMULS,  32'h7F000000, 32'h7F000000, {18'd0, 48'h4000_0000_0000}, 32'h7F800000);
        send(ALU_FMULS,  32'h00000000, 32'h7F800000, {18'd0, 48'h0000_0000_0000}, 32'h7FC00000);
        send(ALU_FMULS,  32'h3F800000, 32'h3F800000, {18'd0, 48'h8000_0080_0000}, 32'h40000000);
        send(ALU_FMULS,  32'h3F800000, 32'h3F800000, {18'd0, 48'h8000_0180_0000}, 32'h40000002);
        send(ALU_FMULS,  32'h3F800000, 32'h3F800000, {18'd0, 48'hFFFF_FF80_0000}, 32'h40800000);
        send(ALU_FMULS,  32'h80800000, 32'h00800000, {18'd0, 48'h4000_0000_0000}, 32'h80000000);
        send(ALU_FMULS,  32'h7F800000, 32'hC0000000, {18'd0, 48'h6000_0000_0000}, 32'hFF800000);
        send(ALU_FMULS,  32'h00000000, 32'hBF800000, {18'd0, 48'h0000_0000_0000}, 32'h80000000);
        drain();

        // Stall: fill both stages, hold output for three cycles
        out_ready = 1'b0;
        send(ALU_MUL, 32'd0, 32'd0, 66'h0_0000_0000_1111_1111, 32'h11111111);
        send(ALU_MUL, 32'd0, 32'd0, 66'h0_0000_0000_2222_2222, 32'h22222222);
        drive(ALU_MUL, 32'd0, 32'd0, 66'h0_0000_0000_3333_3333);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result_held", result, 32'h11111111);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(ALU_MUL, 32'd0, 32'd0, 66'h0_0000_0000_3333_3333, 32'h33333333);
        drain();

        // Reset with both stages valid
        out_ready = 1'b0;
        send(ALU_MULHU, 32'd0, 32'd0, 66'h0_AAAA_AAAA_0000_0000, 32'hAAAAAAAA);
        send(ALU_MULHU, 32'd0, 32'd0, 66'h0_BBBB_BBBB_0000_0000, 32'hBBBBBBBB);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        @(negedge clock);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        send(ALU_FMULS, 32'h40000000, 32'h40400000, {18'd0, 48'h6000_0000_0000}, 32'h40C00000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_result_stage.md
MULT_RESULT_STAGE -- requirements
Module: mult_result_stage

Interface
REQ-001 SHALL have parameter: ROUND_RNE, default 1, 1 = FMULS round-to-nearest-even, 0 = truncate.
REQ-002 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  upstream product valid this cycle.
REQ-005 SHALL have port: in_ready  out  1  stage accepts input this cycle.
REQ-006 SHALL have port: mult_result  in  66  signed product from multiplier (33x33).
REQ-007 SHALL have port: ID_EX_alu_func  in  5  operation code (`ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU, `ALU_FMULS).
REQ-008 SHALL have port: opa  in  32  original operand A (sign/exponent source for FMULS).
REQ-009 SHALL have port: opb  in  32  original operand B.
REQ-010 SHALL have port: out_valid  out  1  result valid.
REQ-011 SHALL have port: out_ready  in  1  downstream accepts result.
REQ-012 SHALL have port: result  out  32  final 32-bit result.

Function
REQ-013 SHALL be a 2-stage pipeline (S1: capture/decode, S2: normalize/round/select), each stage with its own valid bit.
REQ-014 SHALL compute advance = !s2_valid | out_ready; in_ready = advance; both stages update only when advance=1, otherwise hold all contents.
REQ-015 SHALL capture an input into S1 on an edge where in_valid & in_ready; S1 valid then becomes 1, otherwise 0 when advancing.
REQ-016 SHALL have latency 2 edges: input accepted at edge N gives out_valid=1 after edge N+1 when no stall occurs; throughput 1/cycle.
REQ-017 SHALL drive out_valid = s2_valid and result = S2 result register, stable while out_valid & !out_ready.
REQ-018 SHALL in S1 register: func, mult_result[47:0], high word mult_result[63:32], low word mult_result[31:0], sign = opa[31]^opb[31], esum = opa[30:23]+opb[30:23] (10-bit unsigned), plus flags zero (either exponent 0), special (either exponent 8'hFF).
REQ-019 SHALL produce result = low word for `ALU_MUL.
REQ-020 SHALL produce result = high word for `ALU_MULH, `ALU_MULHSU and `ALU_MULHU.
REQ-021 SHALL produce result = low word for any other func code.
REQ-022 SHALL for FMULS take p = mult_result[47:0] (24x24 mantissa product).
REQ-023 SHALL for FMULS when p[47]=1: mant=p[46:24], guard=p[23], sticky=|p[22:0], exp=esum-126.
REQ-024 SHALL for FMULS when p[47]=0: mant=p[45:23], guard=p[22], sticky=|p[21:0], exp=esum-127; exp signed 10-bit.
REQ-025 SHALL for FMULS with ROUND_RNE=1 increment mant when guard & (sticky | mant[0]); on mantissa carry-out set mant=0 and exp+=1.
REQ-026 SHALL for FMULS with ROUND_RNE=0 apply no increment (truncate).
REQ-027 SHALL apply FMULS final selection in priority: special & zero -> 32'h7FC00000; special -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; exp>=255 -> {sign,8'hFF,23'h0}; exp<=0 -> {sign,31'h0}; else {sign,exp[7:0],mant}.
REQ-028 SHALL produce denormal inputs/outputs flushed to signed zero; no exception flags.

Reset
REQ-029 SHALL when reset=1 at an edge clear s1_valid, s2_valid, result to 0 and all pipeline data registers to 0, regardless of in_valid/out_ready.
REQ-030 SHALL discard in-flight operations on reset mid-operation; out_valid=0 in the cycle after reset is sampled; in_ready=1 while reset is held (no S2 valid).

Verification
REQ-031 SHALL cover: `ALU_MUL opa=7, opb=-3 (mult_result=-21 sign-extended) -> result 32'hFFFFFFEB, out_valid two edges after acceptance.
REQ-032 SHALL cover: `ALU_MULH, same product -> 32'hFFFFFFFF; `ALU_MULHU, mult_result=66'h0_FFFFFFFE_00000001 -> 32'hFFFFFFFE.
REQ-033 SHALL cover: `ALU_FMULS opa=32'h40000000, opb=32'h40400000, mult_result=48'h600000000000 -> 32'h40C00000.
REQ-034 SHALL cover: FMULS overflow opa=opb=32'h7F000000 -> 32'h7F800000; opa=32'h00000000, opb=32'h7F800000 -> 32'h7FC00000.
REQ-035 SHALL cover: back-to-back 3 inputs with out_ready=0 for 3 cycles -> in_ready drops once both stages full, result held constant, no loss/duplication after out_ready=1, order preserved.
REQ-036 SHALL cover: reset asserted while both stages valid -> out_valid=0 and result=0 next cycle; next accepted op produces correct result.
